// File: rtl/button_event_gen.sv
// Converts the debounced mode/add/sub levels into single-cycle command events.
// Optional feature macro REPEAT_ACCEL_EN: halve the auto-repeat interval after four repeat pulses.
module button_event_gen #(
    parameter int unsigned LONG_PRESS_COUNT = 150000000,
    parameter int unsigned REPEAT_COUNT     = 20000000
) (
    input  logic clock,
    input  logic reset,
    input  logic mode_button,
    input  logic add_button,
    input  logic sub_button,
    output logic mode_short,
    output logic mode_long,
    output logic add_pulse,
    output logic sub_pulse
);
    localparam logic [31:0] LONG_CNT   = 32'(LONG_PRESS_COUNT);
    localparam logic [31:0] REPEAT_CNT = 32'(REPEAT_COUNT);
`ifdef REPEAT_ACCEL_EN
    localparam logic [31:0] FAST_CNT   = (REPEAT_COUNT / 2 > 0) ? 32'(REPEAT_COUNT / 2) : 32'd1;
`endif

    typedef enum logic [1:0] {M_IDLE, M_PRESSED, M_HELD} mode_state_t;
    typedef enum logic [2:0] {AS_IDLE, ADD_HOLD, ADD_RPT, SUB_HOLD, SUB_RPT} as_state_t;

    mode_state_t mode_state, mode_state_next;
    as_state_t   as_state, as_state_next;
    logic [31:0] mode_cnt, mode_cnt_next, mode_cnt_inc;
    logic [31:0] as_cnt, as_cnt_next, as_cnt_inc;
    logic [31:0] repeat_interval;
    logic        mode_prev, add_prev, sub_prev;
    logic        mode_rise, add_rise, sub_rise;
    logic        mode_short_next, mode_long_next, add_pulse_next, sub_pulse_next;
    logic        as_emit, as_is_add, as_owner_add, as_held;
`ifdef REPEAT_ACCEL_EN
    logic [2:0]  rpt_cnt, rpt_cnt_next;
`endif

    assign mode_rise = mode_button & ~mode_prev;
    assign add_rise  = add_button & ~add_prev;
    assign sub_rise  = sub_button & ~sub_prev;

    // Hold counters saturate instead of wrapping on very long presses.
    assign mode_cnt_inc = (mode_cnt == '1) ? mode_cnt : mode_cnt + 32'd1;
    assign as_cnt_inc   = (as_cnt == '1) ? as_cnt : as_cnt + 32'd1;

    assign as_owner_add = (as_state == ADD_HOLD) || (as_state == ADD_RPT);
    assign as_held      = as_owner_add ? add_button : sub_button;

`ifdef REPEAT_ACCEL_EN
    assign repeat_interval = (rpt_cnt >= 3'd4) ? FAST_CNT : REPEAT_CNT;
`else
    assign repeat_interval = REPEAT_CNT;
`endif

    // NOTE: previous-sample registers reset to 1, so a button already held when
    // reset is released must be released and pressed again before it fires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_state <= M_IDLE;
            as_state   <= AS_IDLE;
            mode_cnt   <= '0;
            as_cnt     <= '0;
            mode_prev  <= 1'b1;
            add_prev   <= 1'b1;
            sub_prev   <= 1'b1;
            mode_short <= 1'b0;
            mode_long  <= 1'b0;
            add_pulse  <= 1'b0;
            sub_pulse  <= 1'b0;
`ifdef REPEAT_ACCEL_EN
            rpt_cnt    <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment so every register
            // samples the pre-edge values regardless of statement order.
            mode_state <= mode_state_next;
            as_state   <= as_state_next;
            mode_cnt   <= mode_cnt_next;
            as_cnt     <= as_cnt_next;
            mode_prev  <= mode_button;
            add_prev   <= add_button;
            sub_prev   <= sub_button;
            mode_short <= mode_short_next;
            mode_long  <= mode_long_next;
            add_pulse  <= add_pulse_next;
            sub_pulse  <= sub_pulse_next;
`ifdef REPEAT_ACCEL_EN
            rpt_cnt    <= rpt_cnt_next;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        mode_state_next = mode_state;
        mode_cnt_next   = mode_cnt_inc;
        mode_short_next = 1'b0;
        mode_long_next  = 1'b0;
        case (mode_state)
            M_IDLE: begin
                mode_cnt_next = mode_cnt;
                if (mode_rise) begin
                    mode_state_next = M_PRESSED;
                    mode_cnt_next   = '0;
                end
            end
            M_PRESSED: begin
                if (!mode_button) begin
                    mode_state_next = M_IDLE;
                    mode_cnt_next   = mode_cnt;
                    mode_short_next = 1'b1;
                end else if (mode_cnt_inc == LONG_CNT) begin
                    mode_state_next = M_HELD;
                    mode_long_next  = 1'b1;
                end
            end
            M_HELD: begin
                if (!mode_button) begin
                    mode_state_next = M_IDLE;
                    mode_cnt_next   = mode_cnt;
                end
            end
            default: begin
                mode_state_next = M_IDLE;
                mode_cnt_next   = '0;
            end
        endcase
    end

    // Add wins a simultaneous press; the owner button alone drives the FSM until release.
    always_comb begin
        as_state_next = as_state;
        as_cnt_next   = as_cnt_inc;
        as_emit       = 1'b0;
        as_is_add     = as_owner_add;
`ifdef REPEAT_ACCEL_EN
        rpt_cnt_next  = rpt_cnt;
`endif
        case (as_state)
            AS_IDLE: begin
                as_cnt_next = as_cnt;
                as_is_add   = add_rise;
                if (add_rise) begin
                    as_state_next = ADD_HOLD;
                    as_cnt_next   = '0;
                    as_emit       = 1'b1;
                end else if (sub_rise) begin
                    as_state_next = SUB_HOLD;
                    as_cnt_next   = '0;
                    as_emit       = 1'b1;
                end
            end
            ADD_HOLD, SUB_HOLD: begin
                if (!as_held) begin
                    as_state_next = AS_IDLE;
                    as_cnt_next   = as_cnt;
                end else if (as_cnt_inc == LONG_CNT) begin
                    as_state_next = as_owner_add ? ADD_RPT : SUB_RPT;
                    as_cnt_next   = '0;
                    as_emit       = 1'b1;
`ifdef REPEAT_ACCEL_EN
                    rpt_cnt_next  = 3'd1;
`endif
                end
            end
            ADD_RPT, SUB_RPT: begin
                if (!as_held) begin
                    as_state_next = AS_IDLE;
                    as_cnt_next   = as_cnt;
`ifdef REPEAT_ACCEL_EN
                    rpt_cnt_next  = '0;
`endif
                end else if (as_cnt_inc == repeat_interval) begin
                    as_cnt_next   = '0;
                    as_emit       = 1'b1;
`ifdef REPEAT_ACCEL_EN
                    rpt_cnt_next  = (rpt_cnt == 3'd4) ? rpt_cnt : rpt_cnt + 3'd1;
`endif
                end
            end
            default: begin
                as_state_next = AS_IDLE;
                as_cnt_next   = '0;
            end
        endcase
        add_pulse_next = as_emit & as_is_add;
        sub_pulse_next = as_emit & ~as_is_add;
    end

endmodule
